// File: rtl/trap_pkg.sv
// Shared types for the trap-return path.
// Build macro: TRAP_CAUSE_EN adds the cause field to each frame.
package trap_pkg;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_ILL_PC    = 2'b01;
    localparam logic [1:0] CAUSE_ILL_MEM   = 2'b10;
    localparam logic [1:0] CAUSE_BAD_INSTR = 2'b11;

    localparam logic [1:0] MODE_RESET = 2'b01;

    localparam int FRAME_PC_W = 16;

`ifdef TRAP_CAUSE_EN
    typedef struct packed {
        logic [1:0]            cause;
        logic [1:0]            mode;
        logic [FRAME_PC_W-1:0] pc;
    } frame_t;
`else
    typedef struct packed {
        logic [1:0]            mode;
        logic [FRAME_PC_W-1:0] pc;
    } frame_t;
`endif

    typedef enum logic {
        IDLE,
        RETURN
    } state_t;

endpackage

// File: rtl/trap_frame_stack.sv
// LIFO of trap frames; parent guarantees push and pop never coincide.
// Build macro: TRAP_CAUSE_EN (frame layout only).
module trap_frame_stack
    import trap_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  frame_t        din,
    output frame_t        top,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    frame_t        mem [DEPTH];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign wr_idx  = IW'(count);
    assign rd_idx  = IW'(count - CW'(1));
    assign top     = mem[rd_idx];

    // Frame storage; no reset needed, count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            unique case (1'b1)
                do_push: count <= count + CW'(1);
                do_pop:  count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/trap_return.sv
// Trap-return unit: pushes frames on traps, pops them on RTI.
// Build macro: TRAP_CAUSE_EN enables stored causes on cause_out.
module trap_return
    import trap_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       store_current,
    input  logic [PC_W-1:0]            cur_pc,
    input  logic [1:0]                 cur_mode,
    input  logic [1:0]                 cause,
    input  logic                       rti,
    input  logic                       flush,
    output logic                       ret_j,
    output logic [PC_W-1:0]            ret_pc,
    output logic [1:0]                 mode_restore,
    output logic                       mode_restore_vld,
    output logic [1:0]                 cause_out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       double_fault,
    output logic                       rti_underflow
);

    localparam int CW = $clog2(DEPTH + 1);

    state_t state;
    state_t state_nxt;
    frame_t din;
    frame_t top;
    logic   full;
    logic   empty;
    logic   accept;
    logic   do_push;
    logic   do_pop;
    logic   in_ret;

    assign din.pc   = FRAME_PC_W'(cur_pc);
    assign din.mode = cur_mode;
`ifdef TRAP_CAUSE_EN
    assign din.cause = cause;
    assign cause_out = empty ? CAUSE_NONE : top.cause;
`else
    logic unused_cause;
    assign unused_cause = &{1'b0, cause};
    assign cause_out    = CAUSE_NONE;
`endif

    trap_frame_stack #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .pop   (do_pop),
        .din   (din),
        .top   (top),
        .count (depth),
        .full  (full),
        .empty (empty)
    );

    // Trap in the RETURN cycle masks the redirect and blocks the pop.
    assign in_ret           = (state == RETURN);
    assign ret_j            = in_ret & ~store_current;
    assign mode_restore_vld = in_ret & ~store_current;

    // Handshake decode and next-state selection.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        do_push   = store_current & ~full;
        do_pop    = 1'b0;
        unique case (state)
            IDLE: begin
                accept = rti & ~flush & ~store_current;
                if (accept & ~empty) begin
                    state_nxt = RETURN;
                end
            end
            RETURN: begin
                do_pop    = ~store_current;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Return target, restore mode and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_pc        <= '0;
            mode_restore  <= MODE_RESET;
            rti_underflow <= 1'b0;
            double_fault  <= 1'b0;
        end else begin
            if (accept & ~empty) begin
                ret_pc       <= PC_W'(top.pc);
                mode_restore <= top.mode;
            end
            rti_underflow <= accept & empty;
            if (store_current & full) begin
                double_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trap_return.sv
// Directed bench for trap_return.
// Build macro: TRAP_CAUSE_EN changes expected cause_out.
module tb_trap_return;

    logic        clk;
    logic        rst;
    logic        store_current;
    logic [15:0] cur_pc;
    logic [1:0]  cur_mode;
    logic [1:0]  cause;
    logic        rti;
    logic        flush;
    logic        ret_j;
    logic [15:0] ret_pc;
    logic [1:0]  mode_restore;
    logic        mode_restore_vld;
    logic [1:0]  cause_out;
    logic [2:0]  depth;
    logic        double_fault;
    logic        rti_underflow;

    int checks;
    int errors;

    trap_return #(
        .DEPTH (4),
        .PC_W  (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .store_current    (store_current),
        .cur_pc           (cur_pc),
        .cur_mode         (cur_mode),
        .cause            (cause),
        .rti              (rti),
        .flush            (flush),
        .ret_j            (ret_j),
        .ret_pc           (ret_pc),
        .mode_restore     (mode_restore),
        .mode_restore_vld (mode_restore_vld),
        .cause_out        (cause_out),
        .depth            (depth),
        .double_fault     (double_fault),
        .rti_underflow    (rti_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] ec(input logic [1:0] c);
`ifdef TRAP_CAUSE_EN
        return c;
`else
        return 2'b00 & c;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push(input logic [15:0] pc,
                        input logic [1:0] m,
                        input logic [1:0] c);
        store_current = 1'b1;
        cur_pc        = pc;
        cur_mode      = m;
        cause         = c;
        step();
        store_current = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (depth !== 3'd0) begin
            errors++;
            $display("FAIL reset_depth got %0d exp 0", depth);
        end
        checks++;
        if (ret_j !== 1'b0 || mode_restore_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_ret got %b%b exp 00",
                     ret_j, mode_restore_vld);
        end
        checks++;
        if (ret_pc !== 16'h0 || mode_restore !== 2'b01) begin
            errors++;
            $display("FAIL reset_regs got %h/%b exp 0000/01",
                     ret_pc, mode_restore);
        end
        checks++;
        if (cause_out !== 2'b00 || double_fault !== 1'b0 ||
            rti_underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got %b%b%b exp 0000",
                     cause_out, double_fault, rti_underflow);
        end
    endtask

    task automatic test_single();
        push(16'h0123, 2'b01, 2'b10);
        checks++;
        if (depth !== 3'd1 || cause_out !== ec(2'b10)) begin
            errors++;
            $display("FAIL single_push got %0d/%b exp 1/%b",
                     depth, cause_out, ec(2'b10));
        end
        rti = 1'b1;
        step();
        rti = 1'b0;
        checks++;
        if (ret_j !== 1'b1 || mode_restore_vld !== 1'b1 ||
            ret_pc !== 16'h0123 || mode_restore !== 2'b01 ||
            depth !== 3'd1) begin
            errors++;
            $display("FAIL single_ret got %b%b %h %b %0d exp 11 0123 01 1",
                     ret_j, mode_restore_vld, ret_pc, mode_restore, depth);
        end
        step();
        checks++;
        if (ret_j !== 1'b0 || mode_restore_vld !== 1'b0 ||
            depth !== 3'd0 || ret_pc !== 16'h0123 ||
            cause_out !== 2'b00) begin
            errors++;
            $display("FAIL single_after got %b%b %0d %h %b exp 00 0 0123 00",
                     ret_j, mode_restore_vld, depth, ret_pc, cause_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] epc [3];
        logic [1:0]  emd [3];
        logic [1:0]  ecs [3];
        epc = '{16'h0030, 16'h0020, 16'h0010};
        emd = '{2'b11, 2'b10, 2'b00};
        ecs = '{2'b10, 2'b11, 2'b01};
        push(16'h0010, 2'b00, 2'b01);
        push(16'h0020, 2'b10, 2'b11);
        push(16'h0030, 2'b11, 2'b10);
        checks++;
        if (depth !== 3'd3) begin
            errors++;
            $display("FAIL nest_depth got %0d exp 3", depth);
        end
        rti = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cause_out !== ec(ecs[i])) begin
                errors++;
                $display("FAIL nest_cause%0d got %b exp %b",
                         i, cause_out, ec(ecs[i]));
            end
            step();
            if (i == 2) rti = 1'b0;
            checks++;
            if (ret_j !== 1'b1 || ret_pc !== epc[i] ||
                mode_restore !== emd[i]) begin
                errors++;
                $display("FAIL nest_ret%0d got %b %h %b exp 1 %h %b",
                         i, ret_j, ret_pc, mode_restore, epc[i], emd[i]);
            end
            step();
            checks++;
            if (ret_j !== 1'b0 || depth !== 3'(2 - i)) begin
                errors++;
                $display("FAIL nest_pop%0d got %b %0d exp 0 %0d",
                         i, ret_j, depth, 2 - i);
            end
        end
    endtask

    task automatic test_full();
        logic [1:0] cs [5];
        cs = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(16'h0100 + 16'(i), 2'(i), cs[i]);
        end
        checks++;
        if (depth !== 3'd4 || double_fault !== 1'b0) begin
            errors++;
            $display("FAIL full_four got %0d/%b exp 4/0",
                     depth, double_fault);
        end
        push(16'h0104, 2'b00, cs[4]);
        checks++;
        if (depth !== 3'd4 || double_fault !== 1'b1 ||
            cause_out !== ec(2'b01)) begin
            errors++;
            $display("FAIL full_five got %0d/%b/%b exp 4/1/%b",
                     depth, double_fault, cause_out, ec(2'b01));
        end
        rti = 1'b1;
        step();
        rti = 1'b0;
        checks++;
        if (ret_j !== 1'b1 || ret_pc !== 16'h0103 ||
            mode_restore !== 2'b11) begin
            errors++;
            $display("FAIL full_top got %b %h %b exp 1 0103 11",
                     ret_j, ret_pc, mode_restore);
        end
        step();
        checks++;
        if (depth !== 3'd3 || double_fault !== 1'b1) begin
            errors++;
            $display("FAIL full_sticky got %0d/%b exp 3/1",
                     depth, double_fault);
        end
        do_reset();
        checks++;
        if (double_fault !== 1'b0 || depth !== 3'd0) begin
            errors++;
            $display("FAIL full_clear got %b/%0d exp 0/0",
                     double_fault, depth);
        end
    endtask

    task automatic test_underflow_flush();
        rti = 1'b1;
        step();
        rti = 1'b0;
        checks++;
        if (rti_underflow !== 1'b1 || ret_j !== 1'b0) begin
            errors++;
            $display("FAIL uf_pulse got %b/%b exp 1/0",
                     rti_underflow, ret_j);
        end
        step();
        checks++;
        if (rti_underflow !== 1'b0 || ret_j !== 1'b0) begin
            errors++;
            $display("FAIL uf_end got %b/%b exp 0/0",
                     rti_underflow, ret_j);
        end
        push(16'h0AAA, 2'b10, 2'b11);
        rti   = 1'b1;
        flush = 1'b1;
        step();
        rti   = 1'b0;
        flush = 1'b0;
        checks++;
        if (ret_j !== 1'b0 || depth !== 3'd1 ||
            rti_underflow !== 1'b0) begin
            errors++;
            $display("FAIL flush_kill got %b %0d %b exp 0 1 0",
                     ret_j, depth, rti_underflow);
        end
        rti = 1'b1;
        push(16'h0BBB, 2'b00, 2'b01);
        rti = 1'b0;
        checks++;
        if (ret_j !== 1'b0 || depth !== 3'd2 ||
            cause_out !== ec(2'b01)) begin
            errors++;
            $display("FAIL trap_rti got %b %0d %b exp 0 2 %b",
                     ret_j, depth, cause_out, ec(2'b01));
        end
        do_reset();
    endtask

    task automatic test_trap_in_return();
        push(16'h0055, 2'b01, 2'b01);
        rti = 1'b1;
        step();
        rti           = 1'b0;
        store_current = 1'b1;
        cur_pc        = 16'h0066;
        cur_mode      = 2'b10;
        cause         = 2'b11;
        #1;
        checks++;
        if (ret_j !== 1'b0 || mode_restore_vld !== 1'b0) begin
            errors++;
            $display("FAIL tir_mask got %b%b exp 00",
                     ret_j, mode_restore_vld);
        end
        step();
        store_current = 1'b0;
        checks++;
        if (ret_j !== 1'b0 || depth !== 3'd2 ||
            cause_out !== ec(2'b11)) begin
            errors++;
            $display("FAIL tir_push got %b %0d %b exp 0 2 %b",
                     ret_j, depth, cause_out, ec(2'b11));
        end
        rti   = 1'b1;
        flush = 1'b0;
        step();
        rti   = 1'b0;
        flush = 1'b1;
        #1;
        checks++;
        if (ret_j !== 1'b1 || ret_pc !== 16'h0066 ||
            mode_restore !== 2'b10) begin
            errors++;
            $display("FAIL tir_ret got %b %h %b exp 1 0066 10",
                     ret_j, ret_pc, mode_restore);
        end
        step();
        flush = 1'b0;
        checks++;
        if (depth !== 3'd1) begin
            errors++;
            $display("FAIL tir_pop got %0d exp 1", depth);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_return();
        push(16'h0777, 2'b11, 2'b10);
        rti = 1'b1;
        step();
        rti = 1'b0;
        checks++;
        if (ret_j !== 1'b1 || mode_restore !== 2'b11) begin
            errors++;
            $display("FAIL rmr_enter got %b/%b exp 1/11",
                     ret_j, mode_restore);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (ret_j !== 1'b0 || depth !== 3'd0 ||
            mode_restore !== 2'b01 || ret_pc !== 16'h0 ||
            mode_restore_vld !== 1'b0) begin
            errors++;
            $display("FAIL rmr_after got %b %0d %b %h %b exp 0 0 01 0000 0",
                     ret_j, depth, mode_restore, ret_pc, mode_restore_vld);
        end
        step();
        checks++;
        if (ret_j !== 1'b0 || depth !== 3'd0) begin
            errors++;
            $display("FAIL rmr_idle got %b/%0d exp 0/0", ret_j, depth);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        store_current = 1'b0;
        cur_pc        = '0;
        cur_mode      = '0;
        cause         = '0;
        rti           = 1'b0;
        flush         = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_underflow_flush();
        test_trap_in_return();
        test_reset_mid_return();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
